// File: rtl/axi_wr_pkg.sv
// -----------------------------------------------------------------------------
// axi_wr_pkg
// Shared definitions for the AXI burst writer:
//   - wr_state_e    : writer FSM states (IDLE, ADDR, DATA, RESP)
//   - RESP_OK/ERR   : BRESP encodings used by the attached memory
//   - AWBURST_INCR  : incrementing burst type
//   - burst_awlen() : AWLEN for the next burst, min(remaining, max_burst) - 1
// -----------------------------------------------------------------------------
package axi_wr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } wr_state_e;

    localparam logic [1:0] RESP_OK      = 2'b01;
    localparam logic [1:0] RESP_ERR     = 2'b10;
    localparam logic       AWBURST_INCR = 1'b1;

    // A remaining count of zero maps to AWLEN 0 so the idle value stays benign.
    function automatic logic [7:0] burst_awlen(input logic [8:0] remaining,
                                               input logic [8:0] max_burst);
        logic [8:0] beats;
        logic [8:0] len9;
        if (remaining == 9'd0) begin
            beats = 9'd1;
        end else if (remaining < max_burst) begin
            beats = remaining;
        end else begin
            beats = max_burst;
        end
        len9 = beats - 9'd1;
        return len9[7:0];
    endfunction

endpackage

// File: rtl/axi_burst_writer_if.sv
// -----------------------------------------------------------------------------
// axi_burst_writer_if
// AXI write-channel bundle (AW, W, B) between the burst writer and memory.
//   master : driven by the writer (AWVALID/AWADDR/AWBURST/AWLEN, WVALID/WDATA/
//            WLAST, BREADY), receives AWREADY, WREADY, BVALID, BRESP
//   slave  : the memory side, mirror image of master
// -----------------------------------------------------------------------------
interface axi_burst_writer_if #(
    parameter int W_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH   = 32
);
    logic                    AWVALID;
    logic                    AWREADY;
    logic [W_ADDR_WIDTH-1:0] AWADDR;
    logic                    AWBURST;
    logic [7:0]              AWLEN;
    logic                    WVALID;
    logic                    WREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic                    WLAST;
    logic                    BVALID;
    logic                    BREADY;
    logic [1:0]              BRESP;

    modport master (
        output AWVALID, AWADDR, AWBURST, AWLEN, WVALID, WDATA, WLAST, BREADY,
        input  AWREADY, WREADY, BVALID, BRESP
    );

    modport slave (
        input  AWVALID, AWADDR, AWBURST, AWLEN, WVALID, WDATA, WLAST, BREADY,
        output AWREADY, WREADY, BVALID, BRESP
    );
endinterface

// File: rtl/axi_wr_beat_ctr.sv
// -----------------------------------------------------------------------------
// axi_wr_beat_ctr
// Counts data beats inside the current burst and flags the final beat.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart counting (address handshake of a new burst)
//   beat       : a data beat transfers this cycle
//   awlen      : beats minus 1 of the current burst
//   last       : current beat is the final one (count == awlen)
// -----------------------------------------------------------------------------
module axi_wr_beat_ctr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       beat,
    input  logic [7:0] awlen,
    output logic       last
);
    logic [7:0] cnt_r;

    // In-burst beat counter, zeroed at the start of every burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 8'd0;
        end else if (clr) begin
            cnt_r <= 8'd0;
        end else if (beat) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign last = (cnt_r == awlen);

endmodule

// File: rtl/axi_burst_writer.sv
// -----------------------------------------------------------------------------
// axi_burst_writer
// Splits a command of cmd_len+1 words into AXI incrementing bursts of at most
// MAX_BURST beats, streams s_data words onto the W channel and collects the
// B responses. done pulses once per command; err is sticky until the next
// command is accepted.
// Ports:
//   ACLK, ARESETn          : clock, asynchronous active-low reset
//   cmd_valid/ready/addr/len: transfer request (len = words - 1)
//   s_valid/ready/data     : input word stream
//   W_EN                   : memory write enable (high while busy)
//   axi (master)           : AW / W / B channels
//   done, err              : end-of-transfer pulse, sticky error
// Build option: define AXI_WR_TIMEOUT_EN to add a B-response watchdog of
// TIMEOUT cycles that aborts the transfer with err set.
// -----------------------------------------------------------------------------
module axi_burst_writer
    import axi_wr_pkg::*;
#(
    parameter int W_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_BURST    = 16,
    parameter int TIMEOUT      = 255
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [W_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    output logic                    W_EN,
    axi_burst_writer_if.master      axi,
    output logic                    done,
    output logic                    err
);
    localparam logic [8:0] MAX_BURST_C = 9'(MAX_BURST);

    wr_state_e               state_r;
    wr_state_e               state_nxt_s;
    logic [8:0]              remaining_r;
    logic [W_ADDR_WIDTH-1:0] addr_r;
    logic [7:0]              awlen_r;
    logic                    cmd_ready_r;
    logic                    done_r;
    logic                    err_r;

    logic                    accept_s;
    logic                    aw_hs_s;
    logic                    beat_s;
    logic                    last_s;
    logic                    b_hs_s;
    logic                    timeout_s;
    logic                    finish_s;
    logic [8:0]              cmd_beats_s;
    logic [8:0]              burst_beats_s;
    logic [8:0]              rem_after_s;

    assign accept_s      = (state_r == IDLE) && cmd_valid && cmd_ready_r;
    assign aw_hs_s       = (state_r == ADDR) && axi.AWREADY;
    assign beat_s        = (state_r == DATA) && s_valid && axi.WREADY;
    assign b_hs_s        = (state_r == RESP) && axi.BVALID;
    assign cmd_beats_s   = {1'b0, cmd_len} + 9'd1;
    assign burst_beats_s = {1'b0, awlen_r} + 9'd1;
    assign rem_after_s   = remaining_r - burst_beats_s;
    assign finish_s      = (b_hs_s && (rem_after_s == 9'd0)) || timeout_s;

`ifdef AXI_WR_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_r;

    // Cycles spent in RESP without a response; cleared everywhere else.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if ((state_r == RESP) && !axi.BVALID) begin
            to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            to_cnt_r <= {TO_W{1'b0}};
        end
    end

    // Fires on the TIMEOUT-th consecutive RESP cycle without BVALID.
    assign timeout_s = (state_r == RESP) && !axi.BVALID &&
                       (to_cnt_r == TO_W'(TIMEOUT - 1));
`else
    assign timeout_s = 1'b0;
`endif

    axi_wr_beat_ctr u_beat_ctr (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .clr   (aw_hs_s),
        .beat  (beat_s),
        .awlen (awlen_r),
        .last  (last_s)
    );

    // Next-state logic of the writer FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt_s = ADDR;
                else          state_nxt_s = IDLE;
            end
            ADDR: begin
                if (aw_hs_s) state_nxt_s = DATA;
                else         state_nxt_s = ADDR;
            end
            DATA: begin
                if (beat_s && last_s) state_nxt_s = RESP;
                else                  state_nxt_s = DATA;
            end
            RESP: begin
                if (finish_s)    state_nxt_s = IDLE;
                else if (b_hs_s) state_nxt_s = ADDR;
                else             state_nxt_s = RESP;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state plus transfer bookkeeping (address, remaining words, status).
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_r     <= IDLE;
            cmd_ready_r <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            addr_r      <= {W_ADDR_WIDTH{1'b0}};
            remaining_r <= 9'd0;
            awlen_r     <= 8'd0;
        end else begin
            state_r     <= state_nxt_s;
            // Registered so cmd_ready first rises on the edge after reset.
            cmd_ready_r <= (state_nxt_s == IDLE);
            done_r      <= finish_s;
            if (accept_s) begin
                addr_r      <= cmd_addr;
                remaining_r <= cmd_beats_s;
                awlen_r     <= burst_awlen(cmd_beats_s, MAX_BURST_C);
                err_r       <= 1'b0;
            end else if (b_hs_s) begin
                // Address wraps modulo 2^W_ADDR_WIDTH; the memory flags range errors.
                addr_r      <= addr_r + W_ADDR_WIDTH'(burst_beats_s);
                remaining_r <= rem_after_s;
                awlen_r     <= burst_awlen(rem_after_s, MAX_BURST_C);
                err_r       <= err_r | (axi.BRESP != RESP_OK);
            end else if (timeout_s) begin
                remaining_r <= 9'd0;
                awlen_r     <= 8'd0;
                err_r       <= 1'b1;
            end else begin
                addr_r      <= addr_r;
                remaining_r <= remaining_r;
                awlen_r     <= awlen_r;
                err_r       <= err_r;
            end
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign done        = done_r;
    assign err         = err_r;
    assign W_EN        = (state_r != IDLE);

    assign axi.AWVALID = (state_r == ADDR);
    assign axi.AWADDR  = addr_r;
    assign axi.AWLEN   = awlen_r;
    assign axi.AWBURST = AWBURST_INCR;

    // W channel is a straight pass-through of the input stream while in DATA.
    assign axi.WVALID  = (state_r == DATA) && s_valid;
    assign axi.WDATA   = s_data;
    assign axi.WLAST   = (state_r == DATA) && last_s;
    assign s_ready     = (state_r == DATA) && axi.WREADY;

    assign axi.BREADY  = (state_r == RESP);

endmodule

// File: tb/tb_axi_burst_writer.sv
// -----------------------------------------------------------------------------
// tb_axi_burst_writer
// Scoreboard bench for axi_burst_writer: expected AW bursts and W beats are
// queued when a command is planned and compared as the DUT emits them.
// Define AXI_WR_TIMEOUT_EN to include the response-watchdog scenario.
// -----------------------------------------------------------------------------
module tb_axi_burst_writer;
    import axi_wr_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MB = 16;
    localparam int TO = 255;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } aw_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } w_t;

    logic          ACLK;
    logic          ARESETn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          W_EN;
    logic          done;
    logic          err;

    axi_burst_writer_if #(.W_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axi_burst_writer #(
        .W_ADDR_WIDTH (AW),
        .DATA_WIDTH   (DW),
        .MAX_BURST    (MB),
        .TIMEOUT      (TO)
    ) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .W_EN      (W_EN),
        .axi       (axi),
        .done      (done),
        .err       (err)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int            tests_run    = 0;
    int            tests_failed = 0;
    aw_t           exp_aw_q[$];
    w_t            exp_w_q[$];
    logic [DW-1:0] src_q[$];
    int            b_pending = 0;
    int            done_cnt  = 0;
    int            w_beats   = 0;
    bit            s_fire    = 1'b0;
    bit            gap_en    = 1'b0;
    bit            ready_rand = 1'b0;
    bit            bvalid_en = 1'b1;
    logic [1:0]    bresp_val = RESP_OK;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: handshakes seen here complete on the following rising edge.
    initial begin
        aw_t e_aw;
        w_t  e_w;
        forever begin
            @(negedge ACLK);
            s_fire = 1'b0;
            if (ARESETn) begin
                if (axi.AWVALID && axi.AWREADY) begin
                    if (exp_aw_q.size() == 0) begin
                        check_val("aw_unexpected", 64'd1, 64'd0);
                    end else begin
                        e_aw = exp_aw_q.pop_front();
                        check_val("awaddr", 64'(axi.AWADDR), 64'(e_aw.addr));
                        check_val("awlen", 64'(axi.AWLEN), 64'(e_aw.len));
                        check_val("awburst", 64'(axi.AWBURST), 64'd1);
                    end
                end
                if (axi.WVALID && axi.WREADY) begin
                    w_beats++;
                    if (exp_w_q.size() == 0) begin
                        check_val("w_unexpected", 64'd1, 64'd0);
                    end else begin
                        e_w = exp_w_q.pop_front();
                        check_val("wdata", 64'(axi.WDATA), 64'(e_w.data));
                        check_val("wlast", 64'(axi.WLAST), 64'(e_w.last));
                    end
                    if (axi.WLAST) b_pending++;
                end
                if (axi.BVALID && axi.BREADY) b_pending--;
                if (s_valid && s_ready) s_fire = 1'b1;
                if (done) done_cnt++;
            end
        end
    end

    // Source stream and memory-side responder, driven just after each edge.
    initial begin
        s_valid     = 1'b0;
        s_data      = '0;
        axi.AWREADY = 1'b0;
        axi.WREADY  = 1'b0;
        axi.BVALID  = 1'b0;
        axi.BRESP   = RESP_OK;
        forever begin
            @(posedge ACLK);
            #1;
            if (s_fire && src_q.size() > 0) void'(src_q.pop_front());
            s_valid     = (src_q.size() > 0) && (!gap_en || ($urandom_range(0, 2) != 0));
            s_data      = (src_q.size() > 0) ? src_q[0] : '0;
            axi.AWREADY = !ready_rand || ($urandom_range(0, 1) != 0);
            axi.WREADY  = !ready_rand || ($urandom_range(0, 2) != 0);
            axi.BVALID  = bvalid_en && (b_pending > 0) &&
                          (axi.BVALID || !ready_rand || ($urandom_range(0, 1) != 0));
            axi.BRESP   = bresp_val;
        end
    end

    // Expected bursts/beats for one command, plus the words to feed in.
    task automatic plan(input logic [AW-1:0] addr, input logic [7:0] len);
        int            rem;
        int            b;
        logic [AW-1:0] a;
        logic [DW-1:0] word;
        rem = int'(len) + 1;
        a   = addr;
        while (rem > 0) begin
            b = (rem < MB) ? rem : MB;
            exp_aw_q.push_back('{addr: a, len: 8'(b - 1)});
            for (int j = 0; j < b; j++) begin
                word = $urandom;
                src_q.push_back(word);
                exp_w_q.push_back('{data: word, last: (j == b - 1)});
            end
            rem -= b;
            a   = a + AW'(b);
        end
    endtask

    // Returns on the cycle after the accepting edge.
    task automatic send_cmd(input logic [AW-1:0] addr, input logic [7:0] len);
        int n;
        n = 0;
        @(posedge ACLK);
        #2;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        do begin
            @(negedge ACLK);
            n++;
        end while (!cmd_ready && n < 50);
        if (!cmd_ready) check_val("cmd_accept_timeout", 64'd0, 64'd1);
        @(posedge ACLK);
        #2;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge ACLK);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_xfer(input string tag, input logic [AW-1:0] addr,
                            input logic [7:0] len, input logic exp_err);
        int d0;
        bit seen;
        d0 = done_cnt;
        plan(addr, len);
        send_cmd(addr, len);
        check_val({tag, "_err_clr"}, 64'(err), 64'd0);
        check_val({tag, "_busy"}, 64'(cmd_ready), 64'd0);
        wait_done(3000, seen);
        check_val({tag, "_done"}, 64'(seen), 64'd1);
        check_val({tag, "_err"}, 64'(err), 64'(exp_err));
        @(negedge ACLK);
        check_val({tag, "_done_1cyc"}, 64'(done), 64'd0);
        repeat (2) @(negedge ACLK);
        check_val({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        check_val({tag, "_aw_left"}, 64'(exp_aw_q.size()), 64'd0);
        check_val({tag, "_w_left"}, 64'(exp_w_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_awvalid"}, 64'(axi.AWVALID), 64'd0);
        check_val({tag, "_wvalid"}, 64'(axi.WVALID), 64'd0);
        check_val({tag, "_wlast"}, 64'(axi.WLAST), 64'd0);
        check_val({tag, "_bready"}, 64'(axi.BREADY), 64'd0);
        check_val({tag, "_w_en"}, 64'(W_EN), 64'd0);
        check_val({tag, "_done"}, 64'(done), 64'd0);
        check_val({tag, "_err"}, 64'(err), 64'd0);
        check_val({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        check_val({tag, "_awaddr"}, 64'(axi.AWADDR), 64'd0);
        check_val({tag, "_awlen"}, 64'(axi.AWLEN), 64'd0);
        check_val({tag, "_awburst"}, 64'(axi.AWBURST), 64'd1);
        check_val({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
    endtask

    task automatic release_reset(input string tag);
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        check_val({tag, "_rdy_before_edge"}, 64'(cmd_ready), 64'd0);
        @(posedge ACLK);
        #1;
        check_val({tag, "_rdy_after_edge"}, 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n;
        bit seen;
        ARESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = 8'd0;
        repeat (3) @(negedge ACLK);
        check_reset_outputs("por");
        release_reset("por");

        run_xfer("single", 10'h010, 8'd3, 1'b0);
        run_xfer("len0", 10'h123, 8'd0, 1'b0);
        run_xfer("multi", 10'h000, 8'd39, 1'b0);

        bresp_val = RESP_ERR;
        run_xfer("wrap_err", 10'h3FE, 8'd3, 1'b1);
        bresp_val = RESP_OK;
        repeat (5) @(negedge ACLK);
        check_val("err_sticky", 64'(err), 64'd1);
        run_xfer("after_err", 10'h050, 8'd1, 1'b0);

        gap_en     = 1'b1;
        ready_rand = 1'b1;
        run_xfer("gaps16", 10'h100, 8'd15, 1'b0);
        run_xfer("gaps40", 10'h3F0, 8'd39, 1'b0);
        gap_en     = 1'b0;
        ready_rand = 1'b0;

        // Reset while the second data beat is on the bus.
        plan(10'h200, 8'd7);
        d0 = w_beats;
        send_cmd(10'h200, 8'd7);
        n = 0;
        while (w_beats < d0 + 1 && n < 200) begin
            @(negedge ACLK);
            #1;
            n++;
        end
        check_val("mid_rst_beat1_seen", 64'(w_beats - d0), 64'd1);
        @(posedge ACLK);
        #2;
        ARESETn = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        exp_aw_q.delete();
        exp_w_q.delete();
        src_q.delete();
        b_pending = 0;
        repeat (2) @(negedge ACLK);
        check_reset_outputs("mid_rst_held");
        release_reset("mid_rst");
        run_xfer("post_rst", 10'h080, 8'd5, 1'b0);

`ifdef AXI_WR_TIMEOUT_EN
        bvalid_en = 1'b0;
        plan(10'h300, 8'd3);
        send_cmd(10'h300, 8'd3);
        n = 0;
        while (!axi.BREADY && n < 200) begin
            @(negedge ACLK);
            n++;
        end
        check_val("to_resp_reached", 64'(axi.BREADY), 64'd1);
        n = 0;
        while (axi.BREADY && n < TO + 10) begin
            n++;
            @(negedge ACLK);
        end
        check_val("to_cycles", 64'(n), 64'(TO));
        check_val("to_done", 64'(done), 64'd1);
        check_val("to_err", 64'(err), 64'd1);
        check_val("to_idle_rdy", 64'(cmd_ready), 64'd1);
        check_val("to_idle_wen", 64'(W_EN), 64'd0);
        b_pending = 0;
        bvalid_en = 1'b1;
        @(negedge ACLK);
        check_val("to_done_1cyc", 64'(done), 64'd0);
        run_xfer("post_to", 10'h040, 8'd2, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
